// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one gate-level full-adder cell, operand shift
// registers, carry flop, bit counter and a start/busy/done handshake.
//
//   state  | meaning
//   IDLE   | waiting for START; outputs hold the last result
//   RUN    | one operand bit pair added per clock, LSB first
//   FINISH | DONE pulse; a new START is accepted here without an idle cycle
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM_OUT,
  output logic             COUT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-2:0] sreg_q, sreg_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             cout_q, cout_d;
  logic             accept;
  logic [WIDTH-1:0] sum_shift;

  wire ab_x, ab_a, cx_a, fa_s, fa_c;

  xor u_x1 (ab_x, areg_q[0], breg_q[0]);
  xor u_x2 (fa_s, ab_x, carry_q);
  and u_a1 (ab_a, areg_q[0], breg_q[0]);
  and u_a2 (cx_a, ab_x, carry_q);
  or  u_o1 (fa_c, ab_a, cx_a);

  always_comb begin
    state_d   = state_q;
    areg_d    = areg_q;
    breg_d    = breg_q;
    sreg_d    = sreg_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_out_d = sum_out_q;
    cout_d    = cout_q;
    accept    = 1'b0;
    // New sum bit enters at the MSB so the result ends up LSB-aligned.
    sum_shift = {fa_s, sreg_q};

    case (state_q)
      IDLE: accept = START;
      RUN: begin
        areg_d  = areg_q >> 1;
        breg_d  = breg_q >> 1;
        sreg_d  = sum_shift[WIDTH-1:1];
        carry_d = fa_c;
        if (cnt_q == LAST) begin
          sum_out_d = sum_shift;
          cout_d    = fa_c;
          state_d   = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        if (START) accept = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      areg_d  = A_IN;
      breg_d  = B_IN;
      carry_d = CIN;
      cnt_d   = '0;
      state_d = RUN;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      areg_q    <= '0;
      breg_q    <= '0;
      sreg_q    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_out_q <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      areg_q    <= areg_d;
      breg_q    <= breg_d;
      sreg_q    <= sreg_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_out_q <= sum_out_d;
      cout_q    <= cout_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign SUM_OUT = sum_out_q;
  assign COUT    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for handshake and
// timing cases, a 4-bit instance for an exhaustive arithmetic sweep.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_vec = 0;
  int n_err = 0;
  int done4_cnt = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .A_IN(a8), .B_IN(b8), .CIN(cin8),
    .BUSY(busy8), .DONE(done8), .SUM_OUT(sum8), .COUT(cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .A_IN(a4), .B_IN(b4), .CIN(cin4),
    .BUSY(busy4), .DONE(done4), .SUM_OUT(sum4), .COUT(cout4)
  );

  always @(negedge clk) if (done4) done4_cnt++;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one 8-bit add, optionally pulse START again at RUN cycle inj,
  // check BUSY and the held previous result every RUN cycle, then the result.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec,
                     input logic [7:0] ps, input logic pc, input int inj);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      start8 = (i == inj);
      a8 = 8'h01; b8 = 8'h01; cin8 = ~cin8;
      chk("run_busy_done", {busy8, done8}, 2'b10);
      chk("run_hold", {cout8, sum8}, {pc, ps});
      tick();
    end
    start8 = 1'b0;
    chk("fin_busy_done", {busy8, done8}, 2'b01);
    chk("fin_sum", sum8, es);
    chk("fin_cout", cout8, ec);
    tick();
    chk("post_idle", {busy8, done8}, 2'b00);
  endtask

  initial begin
    int base_cnt;
    logic [4:0] exp5;

    #2;
    chk("rst_outs8", {busy8, done8, cout8, sum8}, 11'h0);
    chk("rst_outs4", {busy4, done4, cout4, sum4}, 7'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_outs8", {busy8, done8, cout8, sum8}, 11'h0);

    // Basic adds and carry boundaries
    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 8'h00, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h96, 1'b0, 0);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 0);

    // START during RUN must be ignored
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'hFF, 1'b1, 3);
    for (int i = 0; i < 10; i++) begin
      chk("no_extra_op", {busy8, done8, sum8}, {2'b00, 8'h46});
      tick();
    end

    // START held high: back-to-back operations, DONE every 9 cycles
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("b2b1_busy", {busy8, done8}, 2'b10);
      tick();
    end
    chk("b2b1_done", {busy8, done8, cout8, sum8}, {3'b010, 8'h30});
    a8 = 8'h0F; b8 = 8'h01;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("b2b2_busy", {busy8, done8}, 2'b10);
      tick();
    end
    chk("b2b2_done", {busy8, done8, cout8, sum8}, {3'b010, 8'h10});
    start8 = 1'b0;
    tick();
    chk("b2b_idle", {busy8, done8}, 2'b00);

    // Asynchronous reset in RUN cycle 5
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    chk("pre_rst_busy", busy8, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", {busy8, done8, cout8, sum8}, 11'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("post_rst_quiet", {busy8, done8, cout8, sum8}, 11'h0);
      tick();
    end
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 0);

    // Exhaustive 4-bit sweep, back-to-back
    base_cnt = done4_cnt;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
          tick();
          for (int k = 0; k < 4; k++) tick();
          exp5 = 5'(a + b + c);
          chk("w4_result", {busy4, done4, cout4, sum4}, {2'b01, exp5});
        end
      end
    end
    start4 = 1'b0;
    tick();
    tick();
    chk("w4_done_count", done4_cnt - base_cnt, 512);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands, one bit per clock, through a single gate-level full-adder cell (xor/and/or primitives, SUM = A^B^CIN, COUT = majority).
- The cell is instantiated inside this block.
- The block owns the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- It is the area-minimal adder option for the test-design set.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
CLK      input   1      rising-edge clock
RST      input   1      asynchronous active-high reset
START    input   1      request; sampled only when the block is ready (IDLE or FINISH)
A_IN     input   WIDTH  operand A; captured on the accepting edge
B_IN     input   WIDTH  operand B; captured on the accepting edge
CIN      input   1      initial carry-in; captured on the accepting edge
BUSY     output  1      high while in RUN
DONE     output  1      one-cycle pulse; result valid
SUM_OUT  output  WIDTH  result sum; held stable between completions
COUT     output  1      final carry; held with SUM_OUT

Behaviour:
Reset:
- RST high forces, immediately and asynchronously, all of: state=IDLE, BUSY=0, DONE=0, SUM_OUT=0, COUT=0, carry flop=0, counter=0, operand registers=0.
- Reset mid-operation discards the operation; no DONE is produced.

FSM states: IDLE, RUN, FINISH.

IDLE:
- BUSY=0, DONE=0.
- START=1 at an edge: load A_IN, B_IN into shift registers, carry<=CIN, count<=0, go to RUN.

RUN:
- BUSY=1.
- Each edge: the cell computes s,c from areg[0], breg[0], carry.
- s is shifted into the MSB of the internal sum shift register (LSB-first result); areg/breg shift right by 1; carry<=c; count<=count+1.
- On the edge where count==WIDTH-1 (the WIDTH-th bit edge): SUM_OUT<=final shift value, COUT<=c, go to FINISH.
- START is ignored throughout RUN; A_IN/B_IN/CIN may change freely with no effect.

FINISH:
- BUSY=0, DONE=1 for exactly this one cycle.
- Next edge: if START=1, accept a new operation exactly as from IDLE (back-to-back, no idle cycle); otherwise go to IDLE.

Timing and output rules:
- Latency: START sampled at edge E0 → DONE high in the cycle following edge E0+WIDTH. Throughput is one add per WIDTH+1 cycles.
- SUM_OUT/COUT update only on the completion edge; they hold the previous result during RUN and in IDLE.
- Arithmetic is modulo 2^WIDTH. COUT equals bit WIDTH of A_IN+B_IN+CIN.
- Counter width is clog2(WIDTH). The counter does not wrap within an operation and is cleared on every accept.
- BUSY and DONE are never high in the same cycle.
- No combinational path from any input to any output; all outputs are registered or state-decoded.

Test Plan:
1. WIDTH=8: A=0x5A, B=0x3C, CIN=0, START 1 cycle → BUSY high 8 cycles; DONE pulses in the cycle after the 8th edge following accept; SUM_OUT=0x96, COUT=0.
2. A=0xFF, B=0x01, CIN=0 → SUM_OUT=0x00, COUT=1. Then A=0xFF, B=0xFF, CIN=1 → SUM_OUT=0xFF, COUT=1.
3. Second START pulse with A=0x01, B=0x01 asserted mid-RUN (cycle 3 of 8) → ignored; exactly one DONE; result from the first operands only. SUM_OUT holds the old value until the completion edge.
4. START held high continuously with operands 0x10+0x20, then 0x0F+0x01 → DONE every 9 cycles; results 0x30/COUT=0, then 0x10/COUT=0; no IDLE cycle between operations.
5. RST asserted asynchronously (between edges) at RUN cycle 5 → BUSY/DONE/SUM_OUT/COUT drop to 0 immediately; no DONE after release. A fresh 0x80+0x80 afterwards yields SUM_OUT=0x00, COUT=1.
6. Exhaustive check at WIDTH=4: all 512 A/B/CIN combinations → SUM_OUT/COUT match the reference sum; DONE count equals 512.
